// File: rtl/instr_feeder.sv
// Program sequencer for the 9-bit processor: fetches ROM words, issues them with a
// one-cycle run pulse, supplies MVI immediates and waits for Done under a watchdog.
module instr_feeder #(
  parameter int         AW       = 5,
  parameter int         PROG_LEN = 32,
  parameter logic [2:0] MVI_OP   = 3'b001,
  parameter int         TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  output logic [AW-1:0] rom_addr,
  input  logic [8:0]    rom_data,
  output logic [8:0]    DIN,
  output logic          run,
  input  logic          Done,
  output logic          busy,
  output logic          halted,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [7:0]    instr_count
);

  // state   | meaning
  // IDLE    | after reset, awaiting start
  // REQ_I   | instruction address on ROM, pause honoured here
  // CAP_I   | capture instruction word, request immediate
  // CAP_D   | capture MVI immediate word
  // ISSUE   | run pulse, DIN = instruction
  // WAIT    | awaiting Done under watchdog
  // HALT    | program finished
  // ERR     | watchdog expiry or MVI at last address
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ_I = 3'd1;
  localparam logic [2:0] S_CAP_I = 3'd2;
  localparam logic [2:0] S_CAP_D = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam int            WDW     = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);
  localparam logic [AW:0]   LEN_W   = (AW+1)'(PROG_LEN);
  // Expiry on this count puts error high exactly TIMEOUT cycles after the run pulse.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

  logic [2:0]     state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [8:0]     ir_q, ir_d;
  logic [8:0]     imm_q, imm_d;
  logic [8:0]     din_q, din_d;
  logic           mvi_q, mvi_d;
  logic           halted_q, halted_d;
  logic           error_q, error_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [AW:0]    pc_sum;
  logic           launch;
  logic           fetched_mvi;

  assign pc_sum      = {1'b0, pc_q} + (mvi_q ? (AW+1)'(2) : (AW+1)'(1));
  assign launch      = start && (state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR);
  assign fetched_mvi = (rom_data[8:6] == MVI_OP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    din_d    = din_q;
    mvi_d    = mvi_q;
    halted_d = halted_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    rom_addr = pc_q;
    case (state_q)
      S_IDLE: rom_addr = '0;
      S_REQ_I: begin
        if (!pause) state_d = S_CAP_I;
      end
      S_CAP_I: begin
        rom_addr = pc_q + AW'(1);
        ir_d     = rom_data;
        mvi_d    = fetched_mvi;
        if (fetched_mvi) begin
          if (pc_q == LAST_PC) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_CAP_D;
          end
        end else begin
          din_d   = rom_data;
          state_d = S_ISSUE;
        end
      end
      S_CAP_D: begin
        imm_d   = rom_data;
        din_d   = ir_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        din_d   = mvi_q ? imm_q : ir_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          pc_d = pc_sum[AW-1:0];
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (pc_sum >= LEN_W) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_REQ_I;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: ;
    endcase
    if (launch) begin
      pc_d     = '0;
      cnt_d    = '0;
      halted_d = 1'b0;
      error_d  = 1'b0;
      state_d  = S_REQ_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      din_q    <= '0;
      mvi_q    <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      din_q    <= din_d;
      mvi_q    <= mvi_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
    end
  end

  assign DIN         = din_q;
  assign run         = (state_q == S_ISSUE);
  assign busy        = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR);
  assign halted      = halted_q;
  assign error       = error_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Randomized bench for instr_feeder: a program-level model walks the ROM and predicts
// run timing, DIN words, pc/instr_count progression, halt, MVI error and watchdog.
module tb_instr_feeder;
  localparam int         AW  = 5;
  localparam int         PL  = 8;
  localparam int         TO  = 16;
  localparam logic [2:0] MVI = 3'b001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          Done = 1'b0;
  logic [AW-1:0] rom_addr, pc;
  logic [8:0]    rom_data, DIN;
  logic          run, busy, halted, error;
  logic [7:0]    instr_count;
  logic [8:0]    rom [0:31];
  int            n_chk = 0;
  int            n_fail = 0;

  instr_feeder #(.AW(AW), .PROG_LEN(PL), .MVI_OP(MVI), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .rom_addr(rom_addr),
    .rom_data(rom_data), .DIN(DIN), .run(run), .Done(Done), .busy(busy),
    .halted(halted), .error(error), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mvi(input logic [8:0] w);
    return w[8:6] == MVI;
  endfunction

  function automatic logic [8:0] rand_word(input bit allow_mvi);
    logic [8:0] w;
    w = 9'($urandom);
    if (w[8:6] == MVI) w[8:6] = 3'b000;
    if (allow_mvi && $urandom_range(0, 3) == 0) w[8:6] = MVI;
    return w;
  endfunction

  task automatic fill_rom(input bit allow_mvi);
    for (int i = 0; i < 32; i++) rom[i] = rand_word(allow_mvi);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_din"}, DIN, 0);
    check({tag, "_run"}, run, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_icount"}, instr_count, 0);
    check({tag, "_romaddr"}, rom_addr, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Called at the negedge of the cycle where fetch begins; run must appear lat negedges later.
  task automatic wait_run(input int lat, output bit ok);
    int k;
    ok = 1'b0;
    for (k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (run) begin
        ok = 1'b1;
        break;
      end
    end
    check("run_latency", k, lat);
  endtask

  // rst_at >= 0: assert reset in the first WAIT cycle after rst_at instructions completed.
  task automatic exec_prog(input bit rnd, input int rst_at);
    int pcm, cnt, d, p;
    logic [8:0] w, imm;
    bit ok, mv;
    pcm = 0;
    cnt = 0;
    pulse_start();
    check("busy_start", busy, 1);
    check("pc_start", pc, 0);
    check("error_start", error, 0);
    check("halted_start", halted, 0);
    check("icount_start", instr_count, 0);
    while (1) begin
      w  = rom[pcm];
      mv = is_mvi(w);
      if (mv && pcm == PL - 1) begin
        @(negedge clk);
        check("mvi_last_run", run, 0);
        @(negedge clk);
        check("mvi_last_error", error, 1);
        check("mvi_last_busy", busy, 0);
        check("mvi_last_run2", run, 0);
        check("mvi_last_pc", pc, pcm);
        return;
      end
      imm = rom[(pcm + 1) % 32];
      wait_run(mv ? 3 : 2, ok);
      if (!ok) return;
      check("din_run", DIN, w);
      d = rnd ? $urandom_range(1, 6) : 1;
      Done = (d > 1) && ($urandom_range(0, 1) == 1);
      for (int j = 1; j <= d; j++) begin
        @(negedge clk);
        Done  = (j == d);
        start = rnd && ($urandom_range(0, 3) == 0);
        if (j == d) pause = rnd && ($urandom_range(0, 2) == 0);
        check("run_wait", run, 0);
        check("din_wait", DIN, mv ? imm : w);
        if (cnt == rst_at && j == 1) begin
          #1 rst = 1'b0;
          #1 check_reset("async_rst");
          Done = 1'b0; start = 1'b0; pause = 1'b0;
          @(negedge clk);
          check_reset("held_rst");
          rst = 1'b1;
          return;
        end
      end
      @(negedge clk);
      Done  = 1'b0;
      start = 1'b0;
      pcm  += mv ? 2 : 1;
      if (cnt < 255) cnt++;
      check("pc_adv", pc, pcm % 32);
      check("icount", instr_count, cnt);
      if (pcm >= PL) begin
        check("halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_error", error, 0);
        check("halt_din", DIN, mv ? imm : w);
        @(negedge clk);
        pause = 1'b0;
        check("halt_run", run, 0);
        check("halt_din_frozen", DIN, mv ? imm : w);
        return;
      end
      check("busy_run", busy, 1);
      if (pause) begin
        p = $urandom_range(1, 5);
        for (int i = 0; i < p; i++) begin
          Done = 1'($urandom_range(0, 1));
          check("run_paused", run, 0);
          check("pc_paused", pc, pcm);
          @(negedge clk);
        end
        Done  = 1'b0;
        pause = 1'b0;
      end
    end
  endtask

  task automatic timeout_test();
    bit ok;
    fill_rom(1'b0);
    pulse_start();
    wait_run(2, ok);
    if (ok) begin
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        check("wd_error", error, 32'(k == TO));
        check("wd_run", run, 0);
      end
      check("wd_busy", busy, 0);
    end
    exec_prog(1'b1, -1);
  endtask

  initial begin
    #2 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    fill_rom(1'b0);
    rom[0] = 9'h001;
    exec_prog(1'b0, -1);

    fill_rom(1'b0);
    rom[0] = 9'h040;
    rom[1] = 9'h0A5;
    exec_prog(1'b0, -1);

    fill_rom(1'b0);
    rom[PL-1] = 9'h040;
    exec_prog(1'b1, -1);

    timeout_test();

    fill_rom(1'b1);
    exec_prog(1'b1, 1);
    exec_prog(1'b1, -1);

    for (int t = 0; t < 25; t++) begin
      fill_rom(1'b1);
      exec_prog(1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
